led_compare_seq: RTL and testbench

LED_COMPARE_SEQ -- requirements
Module: led_compare_seq

---
 rtl/led_compare_seq.sv | 136 +++++++++++++
 tb/tb_led_compare_seq.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/led_compare_seq.sv
// Two-operand LED comparator: capture A then B from the switches, show the
// compare result steady, blink it, then return to idle with a done pulse.
module led_compare_seq #(
  parameter int unsigned HOLD_CYCLES  = 50000000,
  parameter int unsigned BLINK_CYCLES = 12500000,
  parameter int unsigned BLINK_PHASES = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] sw,
  input  logic       load,
  input  logic       clr,
  output logic       r,
  output logic       g,
  output logic       be,
  output logic       busy,
  output logic       done
);

  localparam int HW = (HOLD_CYCLES  > 1) ? $clog2(HOLD_CYCLES)  : 1;
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam int PW = (BLINK_PHASES > 1) ? $clog2(BLINK_PHASES) : 1;
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);
  localparam logic [PW-1:0] PHASE_LAST = PW'(BLINK_PHASES - 1);

  typedef enum logic [1:0] {IDLE, WAIT_B, SHOW, BLINK} state_e;

  state_e        state_q, state_d;
  logic [1:0]    a_q, a_d, b_q, b_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic [PW-1:0] phase_q, phase_d;
  logic          load_q, load_d;
  logic          armed_q, armed_d;
  logic          done_q, done_d;
  logic          load_evt;
  logic          show;

  // armed_q blocks a load that was already high when reset released.
  assign load_evt = load & ~load_q & armed_q;

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    hold_cnt_d  = hold_cnt_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    load_d      = load;
    armed_d     = armed_q | ~load;
    done_d      = 1'b0;
    if (clr) begin
      state_d     = IDLE;
      hold_cnt_d  = '0;
      blink_cnt_d = '0;
      phase_d     = '0;
    end else begin
      case (state_q)
        IDLE: if (load_evt) begin
          a_d     = sw;
          state_d = WAIT_B;
        end
        WAIT_B: if (load_evt) begin
          b_d         = sw;
          hold_cnt_d  = '0;
          blink_cnt_d = '0;
          phase_d     = '0;
          state_d     = SHOW;
        end
        SHOW, BLINK: begin
          if (load_evt) begin
            a_d         = sw;
            hold_cnt_d  = '0;
            blink_cnt_d = '0;
            phase_d     = '0;
            state_d     = WAIT_B;
          end else if (state_q == SHOW) begin
            if (hold_cnt_q == HOLD_LAST) begin
              blink_cnt_d = '0;
              phase_d     = '0;
              state_d     = BLINK;
            end else begin
              hold_cnt_d = hold_cnt_q + 1'b1;
            end
          end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            if (phase_q == PHASE_LAST) begin
              phase_d = '0;
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              phase_d = phase_q + 1'b1;
            end
          end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      hold_cnt_q  <= '0;
      blink_cnt_q <= '0;
      phase_q     <= '0;
      load_q      <= 1'b0;
      armed_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      hold_cnt_q  <= hold_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      load_q      <= load_d;
      armed_q     <= armed_d;
      done_q      <= done_d;
    end
  end

  // Odd blink phases show the result, even phases are dark.
  assign show = (state_q == SHOW) || ((state_q == BLINK) && phase_q[0]);
  assign r    = show && (a_q > b_q);
  assign g    = show && (a_q < b_q);
  assign be   = show && (a_q == b_q);
  assign busy = (state_q != IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_led_compare_seq.sv
// Directed bench for led_compare_seq with a timeline-based reference model.
module tb_led_compare_seq;
  localparam int HOLD = 4;
  localparam int BLNK = 2;
  localparam int PH   = 4;
  localparam int SEQ_LEN = HOLD + BLNK * PH;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] sw = 2'd0;
  logic       load = 1'b0;
  logic       clr = 1'b0;
  logic       r, g, be, busy, done;

  int checks = 0;
  int failures = 0;

  // Reference: mode 0 idle, 1 waiting for B, 2 running; t = cycles since B
  int m_mode = 0, m_t = 0;
  int m_a = 0, m_b = 0;
  bit m_lq = 0, m_armed = 0, m_done = 0;
  int r_tally = 0, done_tally = 0;

  led_compare_seq #(.HOLD_CYCLES(HOLD), .BLINK_CYCLES(BLNK), .BLINK_PHASES(PH)) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .load(load), .clr(clr),
    .r(r), .g(g), .be(be), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] model_out();
    bit sh;
    sh = 0;
    if (m_mode == 2) begin
      if (m_t < HOLD) sh = 1;
      else sh = (((m_t - HOLD) / BLNK) % 2) == 1;
    end
    return {sh && (m_a > m_b), sh && (m_a < m_b), sh && (m_a == m_b),
            m_mode != 0, m_done};
  endfunction

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: {r,g,be,busy,done} got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_t = 0; m_a = 0; m_b = 0; m_lq = 0; m_armed = 0; m_done = 0;
  endtask

  task automatic tick(input logic [1:0] s, input logic l, input logic c);
    bit evt;
    sw = s; load = l; clr = c;
    evt = l && !m_lq && m_armed;
    m_done = 0;
    if (c) m_mode = 0;
    else if (m_mode == 0) begin
      if (evt) begin m_a = s; m_mode = 1; end
    end else if (m_mode == 1) begin
      if (evt) begin m_b = s; m_mode = 2; m_t = 0; end
    end else begin
      if (evt) begin m_a = s; m_mode = 1; end
      else begin
        m_t++;
        if (m_t == SEQ_LEN) begin m_mode = 0; m_done = 1; end
      end
    end
    m_lq = l;
    if (!l) m_armed = 1;
    @(posedge clk);
    #1;
    check("cycle", {r, g, be, busy, done}, model_out());
    if (r) r_tally++;
    if (done) done_tally++;
  endtask

  task automatic run_idle(input int n);
    for (int i = 0; i < n; i++) tick(2'd0, 1'b0, 1'b0);
  endtask

  // Ends one cycle after B is captured (SHOW, second cycle).
  task automatic load_ab(input logic [1:0] a, input logic [1:0] b);
    tick(a, 1'b1, 1'b0);
    tick(a, 1'b0, 1'b0);
    tick(b, 1'b1, 1'b0);
    tick(b, 1'b0, 1'b0);
  endtask

  logic [1:0] pa [4] = '{2'd1, 2'd2, 2'd0, 2'd3};
  logic [1:0] pb [4] = '{2'd3, 2'd2, 2'd0, 2'd0};
  logic [2:0] prgb [4] = '{3'b010, 3'b001, 3'b001, 3'b100};

  initial begin
    #1;
    check("reset_state", {r, g, be, busy, done}, 5'b00000);
    #11 rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    run_idle(2);

    // A=2, B=1: r steady 4, then off/r/off/r by 2, single done.
    r_tally = 0; done_tally = 0;
    tick(2'd2, 1'b1, 1'b0);
    tick(2'd2, 1'b0, 1'b0);
    tick(2'd1, 1'b1, 1'b0);
    check("show_r_lit", {r, g, be, busy, done}, 5'b10010);
    run_idle(SEQ_LEN + 2);
    check("r_cycles", 5'(r_tally), 5'd8);
    check("done_pulses", 5'(done_tally), 5'd1);

    for (int i = 0; i < 4; i++) begin
      load_ab(pa[i], pb[i]);
      check("rgb_lit", {r, g, be, busy, done}, {prgb[i], 2'b10});
      run_idle(SEQ_LEN);
    end

    // Held load: only A captured, stays waiting for B.
    for (int i = 0; i < 10; i++) tick(2'd1, 1'b1, 1'b0);
    check("held_load_lit", {r, g, be, busy, done}, 5'b00010);
    tick(2'd0, 1'b0, 1'b0);
    tick(2'd0, 1'b1, 1'b0);
    check("after_held_r", {r, g, be, busy, done}, 5'b10010);
    run_idle(SEQ_LEN);

    // Abort during BLINK with sw=3, then B=0 shows A=3 > 0.
    load_ab(2'd1, 2'd2);
    run_idle(4);
    tick(2'd3, 1'b1, 1'b0);
    check("abort_lit", {r, g, be, busy, done}, 5'b00010);
    tick(2'd3, 1'b0, 1'b0);
    tick(2'd0, 1'b1, 1'b0);
    check("abort_a3", {r, g, be, busy, done}, 5'b10010);
    tick(2'd0, 1'b0, 1'b1);
    check("clr_show", {r, g, be, busy, done}, 5'b00000);

    // clr beats a simultaneous load in WAIT_B.
    tick(2'd2, 1'b1, 1'b0);
    tick(2'd2, 1'b0, 1'b0);
    tick(2'd3, 1'b1, 1'b1);
    check("clr_prio_lit", {r, g, be, busy, done}, 5'b00000);
    tick(2'd3, 1'b1, 1'b0);
    tick(2'd3, 1'b0, 1'b0);
    run_idle(2);

    // Asynchronous reset mid-SHOW, load held high across release.
    load_ab(2'd3, 2'd1);
    #2 rst_n = 1'b0; load = 1'b1;
    #1;
    check("async_rst_lit", {r, g, be, busy, done}, 5'b00000);
    model_reset();
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick(2'd0, 1'b1, 1'b0);
    check("post_rst_idle", {r, g, be, busy, done}, 5'b00000);
    tick(2'd0, 1'b0, 1'b0);
    tick(2'd2, 1'b1, 1'b0);
    check("post_rst_load", {r, g, be, busy, done}, 5'b00010);
    run_idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
